// File: rtl/mem_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise data has priority.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic f_req_i,
  input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant_i,
`endif
  output logic grant_vld_o,
  output logic grant_id_o
);

  always_comb begin
    grant_vld_o = f_req_i | d_req_i;
    grant_id_o  = PORT_DATA;
    if (f_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      grant_id_o = (last_grant_i == PORT_DATA) ? PORT_FETCH : PORT_DATA;
`else
      grant_id_o = PORT_DATA;
`endif
    end else if (f_req_i) begin
      grant_id_o = PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: data priority).
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                f_rvalid_q, f_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                grant_vld, grant_id, accept;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  mem_arb_pick u_pick (
    .f_req_i      (f_req),
    .d_req_i      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_vld_o  (grant_vld),
    .grant_id_o   (grant_id)
  );

  // Ready is held low while reset is asserted so no request is accepted then.
  assign accept  = (state_q == ST_IDLE) && !reset && grant_vld;
  assign f_ready = accept && (grant_id == PORT_FETCH);
  assign d_ready = accept && (grant_id == PORT_DATA);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          win_d       = grant_id;
          mem_en_d    = 1'b1;
          mem_we_d    = (grant_id == PORT_DATA) && d_we;
          mem_addr_d  = (grant_id == PORT_DATA) ? d_addr : f_addr;
          mem_wdata_d = (grant_id == PORT_DATA) ? d_wdata : '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = mem_we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (win_q == PORT_DATA) begin
          d_rdata_d  = mem_rdata;
          d_rvalid_d = 1'b1;
        end else begin
          f_rdata_d  = mem_rdata;
          f_rvalid_d = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  assign last_grant_d = accept ? grant_id : last_grant_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      win_q       <= PORT_FETCH;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= PORT_FETCH;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_rvalid_q  <= f_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign f_rvalid  = f_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a timing-rule model.
// Build with or without MEM_ARB_RR_EN; the model follows the same setting.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_ready, f_rvalid, d_ready, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory array with one-cycle registered read.
  logic [DW-1:0] mem_arr [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: transaction timing rules, not state machine.
  int            cyc = 0;
  int            free_at, en_cyc, rv_cyc;
  bit            en_we, rv_port, last_data, exp_fr, exp_dr;
  logic [AW-1:0] en_addr;
  logic [DW-1:0] en_wdata, rv_data, hold_f, hold_d;
  logic [DW-1:0] ref_mem [0:255];

  task automatic model_init();
    free_at   = cyc + 1;
    en_cyc    = -100;
    rv_cyc    = -100;
    hold_f    = '0;
    hold_d    = '0;
    last_data = 1'b0;
    exp_fr    = 1'b0;
    exp_dr    = 1'b0;
  endtask

  task automatic step(input bit fr, input logic [AW-1:0] fa, input bit dr,
                      input bit dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    bit free, acc, win_data;
    @(posedge clk); #1;
    f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    cyc++;
    free = (cyc >= free_at);
    acc  = free && (fr || dr);
    if (fr && dr) begin
`ifdef MEM_ARB_RR_EN
      win_data = !last_data;
`else
      win_data = 1'b1;
`endif
    end else begin
      win_data = dr;
    end
    exp_fr = acc && !win_data;
    exp_dr = acc && win_data;
    if (cyc == rv_cyc) begin
      if (rv_port) hold_d = rv_data;
      else         hold_f = rv_data;
    end
    @(negedge clk);
    chk("f_ready", f_ready, exp_fr);
    chk("d_ready", d_ready, exp_dr);
    chk("busy", busy, !free);
    chk("mem_en", mem_en, cyc == en_cyc);
    chk("mem_we", mem_we, (cyc == en_cyc) && en_we);
    if (cyc == en_cyc) begin
      chk("mem_addr", mem_addr, en_addr);
      if (en_we) chk("mem_wdata", mem_wdata, en_wdata);
    end
    chk("f_rvalid", f_rvalid, (cyc == rv_cyc) && !rv_port);
    chk("d_rvalid", d_rvalid, (cyc == rv_cyc) && rv_port);
    chk("f_rdata", f_rdata, hold_f);
    chk("d_rdata", d_rdata, hold_d);
    if (acc) begin
      last_data = win_data;
      en_cyc    = cyc + 1;
      if (win_data && dwe) begin
        en_we       = 1'b1;
        en_addr     = da;
        en_wdata    = dwd;
        ref_mem[da] = dwd;
        free_at     = cyc + 2;
      end else begin
        en_we   = 1'b0;
        en_addr = win_data ? da : fa;
        rv_cyc  = cyc + 3;
        rv_port = win_data;
        rv_data = ref_mem[en_addr];
        free_at = cyc + 4;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1; f_req = 1'b1; d_req = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_f_ready", f_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_f_rvalid", f_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
    end
    reset = 1'b0; f_req = 1'b0; d_req = 1'b0;
    model_init();
  endtask

  bit            fp, dp, rwe;
  logic [AW-1:0] ra_f, ra_d;
  logic [DW-1:0] rwd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    do_reset(2);

    // Both ports requesting continuously straight after reset.
    for (int i = 0; i < 24; i++) step(1, AW'(i), 1, 0, AW'(i + 32), '0);
    repeat (4) step(0, '0, 0, 0, '0, '0);

    // Data write 0x10 = BEEF, then fetch read of the same word.
    step(0, '0, 1, 1, 8'h10, 16'hBEEF);
    step(0, '0, 0, 0, '0, '0);
    step(1, 8'h10, 0, 0, '0, '0);
    repeat (4) step(0, '0, 0, 0, '0, '0);
    chk("beef_fetch", f_rdata, 16'hBEEF);

    // Fetch request raised for one cycle while a read is in ISSUE.
    step(1, 8'h10, 0, 0, '0, '0);
    step(1, 8'h20, 0, 0, '0, '0);
    repeat (4) step(0, '0, 0, 0, '0, '0);

    fp = 0; dp = 0;
    for (int i = 0; i < 2000; i++) begin
      if (fp && exp_fr) fp = 0;
      if (dp && exp_dr) dp = 0;
      if (fp) begin
        if ($urandom_range(7) == 0) fp = 0;
      end else if ($urandom_range(1) == 1) begin
        fp = 1; ra_f = AW'($urandom_range(15));
      end
      if (dp) begin
        if ($urandom_range(7) == 0) dp = 0;
      end else if ($urandom_range(1) == 1) begin
        dp = 1; ra_d = AW'($urandom_range(15));
        rwe = bit'($urandom_range(1)); rwd = DW'($urandom);
      end
      step(fp, ra_f, dp, rwe, ra_d, rwd);
    end
    repeat (4) step(0, '0, 0, 0, '0, '0);

    // Reset asserted while a data read sits in WAIT.
    step(0, '0, 1, 0, 8'h05, '0);
    chk("midrd_accept", d_ready, 1);
    step(0, '0, 0, 0, '0, '0);
    do_reset(1);
    repeat (6) step(0, '0, 0, 0, '0, '0);

    fp = 0; dp = 0;
    for (int i = 0; i < 300; i++) begin
      if (fp && exp_fr) fp = 0;
      if (dp && exp_dr) dp = 0;
      if (!fp && $urandom_range(1) == 1) begin fp = 1; ra_f = AW'($urandom_range(15)); end
      if (!dp && $urandom_range(1) == 1) begin
        dp = 1; ra_d = AW'($urandom_range(15));
        rwe = bit'($urandom_range(1)); rwd = DW'($urandom);
      end
      step(fp, ra_f, dp, rwe, ra_d, rwd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 16-bit main memory between the CPU's instruction-fetch port (read-only) and data port (read/write). It accepts one request at a time, drives the registered memory control bus and returns read data to the requester that issued it. It sits between the CPU and the memory array built from the team's 16-bit register words. The array has a fixed one-cycle registered read latency.

## Interface
- ADDR_W, 8, word-address width
- DATA_W, 16, data word width

- clk  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch port request
- f_addr  in  ADDR_W  fetch address
- f_ready  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid (one-cycle pulse)
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data port request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid (one-cycle pulse)
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we = 0
- busy  out  1  FSM not in IDLE

## Operation
- **Clock and reset:** single clock, `clk`. Reset is synchronous, active-high, port `reset`.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any request is pending, pick a winner and assert that port's ready combinationally in the same cycle.
  - Register the winner's address, write data and we into mem_addr, mem_wdata and mem_we, and record the winner id. Next state is ISSUE.
  - With no request pending, stay in IDLE.
- **ISSUE:** mem_en = 1.
  - For a write, next state is IDLE.
  - For a read, next state is WAIT.
- **WAIT:** capture mem_rdata into the winner's rdata register. Next state is RESP.
- **RESP:** winner's rvalid = 1 for exactly one cycle. Next state is IDLE.
- **Requester handshake:**
  - A requester holds req, addr, we and wdata stable until ready.
  - Dropping req before ready is legal and creates no access.
  - Ready is never asserted outside IDLE.
  - The fetch port is always a read; d_we is ignored for fetch.
- **Arbitration on simultaneous f_req and d_req:** see Configuration. A single requester is always granted.
- **Read-data hold:** rdata registers hold their last value until the next read completion on the same port.
- **Reset values:** the FSM enters IDLE and every output is 0: ready, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy. The last-grant flag resets to FETCH.
- **Reset mid-operation:** any access in flight is abandoned. No rvalid is issued for it. mem_en drops the cycle after reset is sampled.
- **No write-data forwarding:** a read to an address written by the immediately preceding access returns the new value, because the memory is updated before the read is issued.

## Timing
- **Read:** accept at cycle 0, mem_en at cycle 1, capture at cycle 2, rvalid at cycle 3. The next accept can occur no earlier than cycle 4.
- **Write:** accept at cycle 0, mem_en/mem_we at cycle 1. The next accept can occur at cycle 2.
- **Throughput:** one read per 4 cycles, one write per 2 cycles.
- **Output registering:** ready is the only combinational output (req and state to ready). All memory-side outputs and rvalid/rdata are registered.

## Configuration
- **MEM_ARB_RR_EN defined:** round-robin arbitration. On conflict, grant the port not granted last. The last-grant flag updates on every accept.
- **MEM_ARB_RR_EN undefined:** fixed priority, data port over fetch. The last-grant flag is not implemented.

## Structure
- **Shared package `mem_pkg`:**
  - FSM state enum.
  - Port-id constants PORT_FETCH and PORT_DATA.
  - Default ADDR_W and DATA_W.
- **Sub-module `mem_arb_pick`:** combinational winner selection from f_req, d_req and last_grant. It contains the MEM_ARB_RR_EN variant.

## Test plan
- **Reset values:** assert reset for 2 cycles with both reqs high. Every output must be 0, no ready may be asserted, and busy = 0.
- **Data write then fetch read:** d_req write to addr 0x10 with 0xBEEF; mem_en/mem_we must appear at cycle 1. Then issue f_req read of 0x10; f_rvalid must appear at cycle 3 with f_rdata = 0xBEEF.
- **Simultaneous requests, RR enabled:** hold f_req and d_req continuously. Grants must alternate D, F, D, F… starting with DATA after reset.
- **Simultaneous requests, RR disabled:** same stimulus. Only d_ready may pulse; f_ready must stay 0.
- **Reset mid-read:** accept a d_req read of 0x05, then assert reset in WAIT. d_rvalid must never pulse, and the FSM must be in IDLE with busy = 0 the cycle after reset.
- **Request withdrawn:** raise f_req for 1 cycle while the FSM is in ISSUE, then drop it. No f_ready and no extra mem_en may occur.
